// File: rtl/mem_access_stage.sv
// MEM stage of the RV32I pipeline: turns loads/stores into a req/ack data-memory
// transaction, stalls while it is outstanding, and drives the MEM/WB register.
module mem_access_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteM,
    input  logic        MemWriteM,
    input  logic        MemtoRegM,
    input  logic        PCBranchM,
    input  logic        branchM,
    input  logic [2:0]  strCtrlM,
    input  logic [4:0]  rdM,
    input  logic [31:0] ALUoutM,
    input  logic [31:0] r2M,
    input  logic [31:0] PCplusImmM,
    output logic        PCSrcM,
    output logic [31:0] PCTargetM,
    output logic        stallM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        RegWriteW,
    output logic        MemtoRegW,
    output logic [4:0]  rdW,
    output logic [31:0] ALUoutW,
    output logic [31:0] ReadDataW,
    output logic [1:0]  excW
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [31:0] WD_LAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

    state_t      state_q, state_d;
    logic        req_q, req_d, we_q, we_d, abort_q, abort_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, hold_q, hold_d, wd_q, wd_d;
    logic [3:0]  be_q, be_d;
    logic        rw_w_q, rw_w_d, m2r_w_q, m2r_w_d;
    logic [4:0]  rd_w_q, rd_w_d;
    logic [31:0] alu_w_q, alu_w_d, rdat_w_q, rdat_w_d;
    logic [1:0]  exc_w_q, exc_w_d;

    logic        memop, is_b, is_h, is_w, unsgn, misal, start, wd_expired;
    logic [3:0]  st_be;
    logic [31:0] st_wdata, ld_ext;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign PCSrcM    = PCBranchM & branchM;
    assign PCTargetM = PCplusImmM;

    // strCtrl low bits pick the size: 00 byte, 01 half, anything else is a word.
    assign memop = MemWriteM | MemtoRegM;
    assign is_b  = (strCtrlM[1:0] == 2'b00);
    assign is_h  = (strCtrlM[1:0] == 2'b01);
    assign is_w  = ~is_b & ~is_h;
    assign unsgn = strCtrlM[2] & ~is_w;
    assign misal = (is_h & ALUoutM[0]) | (is_w & (ALUoutM[1:0] != 2'b00));
    assign start = memop & ~misal;
    assign wd_expired = (TIMEOUT != 0) && (wd_q == WD_LAST);

    always_comb begin
        st_be    = 4'b1111;
        st_wdata = r2M;
        if (is_b) begin
            st_be    = 4'b0001 << ALUoutM[1:0];
            st_wdata = {4{r2M[7:0]}};
        end else if (is_h) begin
            st_be    = 4'b0011 << ALUoutM[1:0];
            st_wdata = {2{r2M[15:0]}};
        end
    end

    always_comb begin
        ld_byte = hold_q[7:0];
        case (ALUoutM[1:0])
            2'b01:   ld_byte = hold_q[15:8];
            2'b10:   ld_byte = hold_q[23:16];
            2'b11:   ld_byte = hold_q[31:24];
            default: ld_byte = hold_q[7:0];
        endcase
        ld_half = ALUoutM[1] ? hold_q[31:16] : hold_q[15:0];
        if (is_b)      ld_ext = {{24{ld_byte[7] & ~unsgn}}, ld_byte};
        else if (is_h) ld_ext = {{16{ld_half[15] & ~unsgn}}, ld_half};
        else           ld_ext = hold_q;
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        hold_d  = hold_q;
        abort_d = abort_q;
        wd_d    = wd_q;
        stallM  = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                stallM  = 1'b1;
                state_d = BUSY;
                req_d   = 1'b1;
                we_d    = MemWriteM;
                addr_d  = {ALUoutM[31:2], 2'b00};
                be_d    = st_be;
                wdata_d = st_wdata;
                wd_d    = 32'd0;
                abort_d = 1'b0;
            end
            BUSY: begin
                stallM = 1'b1;
                // ack is tested first so it wins over a simultaneous expiry
                if (dmem_ack) begin
                    hold_d  = dmem_rdata;
                    req_d   = 1'b0;
                    state_d = DONE;
                end else if (wd_expired) begin
                    req_d   = 1'b0;
                    abort_d = 1'b1;
                    state_d = DONE;
                end else begin
                    wd_d = wd_q + 32'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rw_w_d   = rw_w_q;
        m2r_w_d  = m2r_w_q;
        rd_w_d   = rd_w_q;
        alu_w_d  = alu_w_q;
        rdat_w_d = rdat_w_q;
        exc_w_d  = exc_w_q;
        if (stallM) begin
            rw_w_d  = 1'b0;
            exc_w_d = 2'b00;
        end else begin
            if (memop & misal)                      exc_w_d = 2'b01;
            else if (state_q == DONE && abort_q)    exc_w_d = 2'b10;
            else                                    exc_w_d = 2'b00;
            rw_w_d   = RegWriteM & ~(memop & misal) & ~(state_q == DONE && abort_q);
            m2r_w_d  = MemtoRegM;
            rd_w_d   = rdM;
            alu_w_d  = ALUoutM;
            rdat_w_d = (state_q == DONE && !abort_q && MemtoRegM) ? ld_ext : 32'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= 32'd0;
            be_q     <= 4'd0;
            wdata_q  <= 32'd0;
            hold_q   <= 32'd0;
            abort_q  <= 1'b0;
            wd_q     <= 32'd0;
            rw_w_q   <= 1'b0;
            m2r_w_q  <= 1'b0;
            rd_w_q   <= 5'd0;
            alu_w_q  <= 32'd0;
            rdat_w_q <= 32'd0;
            exc_w_q  <= 2'b00;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            hold_q   <= hold_d;
            abort_q  <= abort_d;
            wd_q     <= wd_d;
            rw_w_q   <= rw_w_d;
            m2r_w_q  <= m2r_w_d;
            rd_w_q   <= rd_w_d;
            alu_w_q  <= alu_w_d;
            rdat_w_q <= rdat_w_d;
            exc_w_q  <= exc_w_d;
        end
    end

    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_be    = be_q;
    assign dmem_wdata = wdata_q;
    assign RegWriteW  = rw_w_q;
    assign MemtoRegW  = m2r_w_q;
    assign rdW        = rd_w_q;
    assign ALUoutW    = alu_w_q;
    assign ReadDataW  = rdat_w_q;
    assign excW       = exc_w_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: expected MEM/WB results are queued when an
// op is driven and popped once the stage releases the op.
module tb_mem_access_stage;
    localparam int TO = 4;

    logic        clk = 1'b0, rst = 1'b0;
    logic        RegWriteM = 0, MemWriteM = 0, MemtoRegM = 0, PCBranchM = 0, branchM = 0;
    logic [2:0]  strCtrlM = 0;
    logic [4:0]  rdM = 0;
    logic [31:0] ALUoutM = 0, r2M = 0, PCplusImmM = 0;
    logic        PCSrcM, stallM, dmem_req, dmem_we, dmem_ack = 0;
    logic [31:0] PCTargetM, dmem_addr, dmem_wdata, dmem_rdata = 0;
    logic [3:0]  dmem_be;
    logic        RegWriteW, MemtoRegW;
    logic [4:0]  rdW;
    logic [31:0] ALUoutW, ReadDataW;
    logic [1:0]  excW;

    typedef struct packed {
        logic        rw;
        logic        m2r;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] rdat;
        logic [1:0]  exc;
    } wexp_t;

    wexp_t q[$];
    int checks = 0, errors = 0;

    mem_access_stage #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
        .MemtoRegM(MemtoRegM), .PCBranchM(PCBranchM), .branchM(branchM),
        .strCtrlM(strCtrlM), .rdM(rdM), .ALUoutM(ALUoutM), .r2M(r2M),
        .PCplusImmM(PCplusImmM), .PCSrcM(PCSrcM), .PCTargetM(PCTargetM),
        .stallM(stallM), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .RegWriteW(RegWriteW),
        .MemtoRegW(MemtoRegW), .rdW(rdW), .ALUoutW(ALUoutW),
        .ReadDataW(ReadDataW), .excW(excW)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [2:0] sz,
                                               input logic [1:0] a);
        logic [31:0] sh;
        sh = w >> (8 * a);
        case (sz)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b100:  return {24'd0, sh[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b101:  return {16'd0, sh[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic wexp_t cur_w();
        return {RegWriteW, MemtoRegW, rdW, ALUoutW, ReadDataW, excW};
    endfunction

    // Drive one EX/MEM op at a negedge, act as the memory (ack on busy cycle ackc,
    // 0 = never), then compare the W stage once it has loaded.
    task automatic op(input string tag, input logic rw, input logic st, input logic ld,
                      input logic [2:0] sz, input logic [4:0] rd, input logic [31:0] a,
                      input logic [31:0] r2, input int ackc, input logic [31:0] rdat);
        logic   memop, mis, timeout;
        logic [3:0]  ebe;
        logic [31:0] ewd;
        wexp_t  e;
        int     stalls = 0, n = 0, guard = 0, exp_stall;
        memop   = st | ld;
        mis     = (sz[1:0] == 2'b01) ? a[0] : (sz[1:0] != 2'b00) && (a[1:0] != 2'b00);
        timeout = memop && !mis && (ackc == 0);
        case (sz)
            3'b000, 3'b100: begin ebe = 4'b0001 << a[1:0]; ewd = {4{r2[7:0]}}; end
            3'b001, 3'b101: begin ebe = 4'b0011 << a[1:0]; ewd = {2{r2[15:0]}}; end
            default:        begin ebe = 4'b1111;           ewd = r2; end
        endcase
        exp_stall = (!memop || mis) ? 0 : 1 + (ackc == 0 ? TO : ackc);
        e.rw   = rw && !(memop && mis) && !timeout;
        e.m2r  = ld;
        e.rd   = rd;
        e.alu  = a;
        e.rdat = (ld && !mis && !timeout) ? model_load(rdat, sz, a[1:0]) : 32'd0;
        e.exc  = (memop && mis) ? 2'b01 : (timeout ? 2'b10 : 2'b00);
        q.push_back(e);

        RegWriteM = rw; MemWriteM = st; MemtoRegM = ld; strCtrlM = sz;
        rdM = rd; ALUoutM = a; r2M = r2;
        #1;
        if (memop && mis) chk({tag, " no_req"}, 80'(dmem_req), 80'(1'b0));
        while (stallM === 1'b1 && guard < 64) begin
            stalls++; guard++;
            if (dmem_req === 1'b1) begin
                n++;
                if (n == 1) begin
                    chk({tag, " bus"}, 80'({dmem_we, dmem_addr, dmem_be, dmem_wdata}),
                        80'({st, a[31:2], 2'b00, ebe, ewd}));
                    chk({tag, " bubble"}, 80'(RegWriteW), 80'(1'b0));
                end
                dmem_ack   = (n == ackc);
                dmem_rdata = rdat;
            end
            @(negedge clk);
        end
        dmem_ack = 1'b0;
        chk({tag, " stall_cycles"}, 80'(stalls), 80'(exp_stall));
        @(negedge clk);
        if (q.size() == 0) chk({tag, " queue_empty"}, 80'(1), 80'(0));
        else chk({tag, " W"}, 80'(cur_w()), 80'(q.pop_front()));
    endtask

    initial begin
        @(negedge clk);
        chk("reset bus", 80'({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata}), 80'(0));
        chk("reset W", 80'(cur_w()), 80'(0));
        rst = 1'b1;
        @(negedge clk);

        op("LW",  1, 0, 1, 3'b010, 5'd1, 32'h100, 32'h0, 1, 32'hDEADBEEF);
        op("LB",  1, 0, 1, 3'b000, 5'd2, 32'h103, 32'h0, 1, 32'h80FFFF7F);
        op("LBU", 1, 0, 1, 3'b100, 5'd3, 32'h103, 32'h0, 1, 32'h80FFFF7F);
        op("LH",  1, 0, 1, 3'b001, 5'd4, 32'h202, 32'h0, 3, 32'h8001_7FFF);
        op("LHU", 1, 0, 1, 3'b101, 5'd4, 32'h202, 32'h0, 2, 32'h8001_7FFF);
        op("SH",  0, 1, 0, 3'b001, 5'd0, 32'h22,  32'h1234ABCD, 1, 32'h0);
        op("SB",  0, 1, 0, 3'b000, 5'd0, 32'h41,  32'h000000A5, 2, 32'h0);
        op("MISLW", 1, 0, 1, 3'b010, 5'd6, 32'h102, 32'h0, 1, 32'h0);
        op("MISSH", 0, 1, 0, 3'b101, 5'd0, 32'h33,  32'h0, 1, 32'h0);
        op("TMO", 1, 0, 1, 3'b010, 5'd7, 32'h300, 32'h0, 0, 32'h0);
        op("ACK4", 1, 0, 1, 3'b010, 5'd8, 32'h304, 32'h0, 4, 32'hCAFEF00D);

        // asynchronous reset while BUSY
        RegWriteM = 1; MemtoRegM = 1; MemWriteM = 0; strCtrlM = 3'b010;
        rdM = 5'd9; ALUoutM = 32'h400;
        @(negedge clk);
        chk("rst pre req", 80'(dmem_req), 80'(1'b1));
        rst = 1'b0;
        #1;
        chk("rst req drop", 80'(dmem_req), 80'(1'b0));
        chk("rst W", 80'(cur_w()), 80'(0));
        RegWriteM = 0; MemtoRegM = 0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        PCBranchM = 1; branchM = 0; PCplusImmM = 32'h40;
        #1;
        chk("branch not taken", 80'({PCSrcM, PCTargetM}), 80'({1'b0, 32'h40}));
        branchM = 1;
        #1;
        chk("branch taken", 80'({PCSrcM, PCTargetM}), 80'({1'b1, 32'h40}));
        op("ADD", 1, 0, 0, 3'b000, 5'd5, 32'h55, 32'h0, 1, 32'h0);
        op("LW2", 1, 0, 1, 3'b010, 5'd10, 32'h8, 32'h0, 1, 32'h01234567);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
